// File: rtl/spi_keycode_responder_if.sv
// SPI bus between the external USB-host controller (master) and the
// keycode responder (slave). Mode 0, MSB first.
interface spi_keycode_responder_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_keycode_responder.sv
// SPI responder that receives a two-byte frame {command, data} from the
// USB-host controller and drives the keycode seen by the game logic.
// Returns ID_BYTE during the command byte and a snapshot of the game
// status during the data byte. All SPI pins are oversampled in i_clk.
module spi_keycode_responder #(
    parameter logic [7:0] ID_BYTE = 8'hA5,
    parameter logic [7:0] CMD_KEY = 8'h01,
    parameter logic [7:0] CMD_CLR = 8'h02
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    spi_keycode_responder_if.slave         io_spi,
    input  logic [7:0]                     i_status_in,
    output logic [7:0]                     o_keycode,
    output logic                           o_key_valid,
    output logic                           o_frame_err
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_CMD,
        S_DATA,
        S_OVER
    } state_t;

    // Synchroniser chains; index [1] is the synced value, [2] its history.
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_rise;
    logic       w_cs_fall;
    logic       w_cs_n;
    logic       w_mosi;

    state_t     r_state;
    logic [4:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_cmd;
    logic [7:0] r_data;
    logic [7:0] w_commit_data;

    // Bring the asynchronous SPI pins into the i_clk domain.
    // NOTE: these flops are deliberately not reset so MISO_OE keeps
    // following the chip select while the rest of the block is in reset.
    always_ff @(posedge i_clk) begin
        r_sclk_sync <= {r_sclk_sync[1:0], io_spi.sclk};
        r_cs_sync   <= {r_cs_sync[1:0],   io_spi.cs_n};
        r_mosi_sync <= {r_mosi_sync[0],   io_spi.mosi};
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_n      = r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];

    // If CS_N closes the frame before DATA has latched the byte, the
    // receive shifter already holds it.
    assign w_commit_data = (r_state == S_DATA) ? r_rx_shift : r_data;

    // Frame state machine, shifters, bit counter and registered outputs.
    // NOTE: every register here uses non-blocking assignment so the later
    // load of tx_shift in CMD cleanly overrides the shift earlier in the block.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_WAIT_IDLE;
            r_bit_cnt   <= 5'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_cmd       <= 8'h00;
            r_data      <= 8'h00;
            o_keycode   <= 8'h00;
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;

            case (r_state)
                S_WAIT_IDLE: begin
                    // Never join a frame already in progress.
                    if (w_cs_n) begin
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_tx_shift <= ID_BYTE;
                        r_rx_shift <= 8'h00;
                        r_bit_cnt  <= 5'd0;
                        r_state    <= S_CMD;
                    end
                end

                S_CMD, S_DATA, S_OVER: begin
                    if (w_cs_rise) begin
                        // End of frame has priority over any SCLK edge.
                        if (r_bit_cnt == 5'd16) begin
                            if (r_cmd == CMD_KEY) begin
                                o_keycode   <= w_commit_data;
                                o_key_valid <= 1'b1;
                            end else if (r_cmd == CMD_CLR) begin
                                o_keycode   <= 8'h00;
                                o_key_valid <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[6:0], w_mosi};
                            if (r_bit_cnt != 5'd31) begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end

                        // The status byte is loaded with its MSB already on
                        // MISO, so the falling edge right after bit 8 must
                        // not shift it away.
                        if (w_sclk_fall &&
                            !((r_state == S_DATA) && (r_bit_cnt == 5'd8))) begin
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end

                        if ((r_state == S_CMD) && (r_bit_cnt == 5'd8)) begin
                            r_cmd      <= r_rx_shift;
                            r_tx_shift <= i_status_in;
                            r_state    <= S_DATA;
                        end

                        if ((r_state == S_DATA) && (r_bit_cnt == 5'd16)) begin
                            r_data  <= r_rx_shift;
                            r_state <= S_OVER;
                        end
                    end
                end

                default: begin
                    r_state <= S_WAIT_IDLE;
                end
            endcase
        end
    end

    assign io_spi.miso_oe = ~w_cs_n;
    assign io_spi.miso    = r_tx_shift[7] & ~w_cs_n;

endmodule

// File: tb/tb_spi_keycode_responder.sv
// Directed testbench for spi_keycode_responder: SPI mode 0 frames at
// Clk/8, MISO captured before each SCLK rise, pulses counted by a monitor.
module tb_spi_keycode_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] status_in;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    int kv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int long_cnt = 0;
    logic prev_kv = 1'b0;
    logic prev_fe = 1'b0;

    spi_keycode_responder_if spi ();

    spi_keycode_responder dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .io_spi      (spi),
        .i_status_in (status_in),
        .o_keycode   (keycode),
        .o_key_valid (key_valid),
        .o_frame_err (frame_err)
    );

    always #10 clk = ~clk;

    // Count pulses and flag overlapping or stretched pulses.
    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
        if (key_valid && frame_err) both_cnt++;
        if ((key_valid && prev_kv) || (frame_err && prev_fe)) long_cnt++;
        prev_kv = key_valid;
        prev_fe = frame_err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi.cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        spi.mosi = b;
        wait_clk(4);
        m = spi.miso;
        spi.sclk = 1'b1;
        wait_clk(4);
        spi.sclk = 1'b0;
    endtask

    // Raise CS_N and wait exactly the 4-cycle latency budget.
    task automatic cs_high();
        wait_clk(4);
        spi.cs_n = 1'b1;
        wait_clk(4);
    endtask

    // bits is left-aligned: bit i of the frame is bits[23-i].
    task automatic run_frame(input int n, input logic [23:0] bits,
                             input logic [7:0] late_status,
                             output logic [23:0] mbits);
        logic m;
        mbits = '0;
        cs_low();
        for (int i = 0; i < n; i++) begin
            if (i == 10) status_in = late_status;
            xfer_bit(bits[23-i], m);
            mbits[23-i] = m;
        end
        cs_high();
    endtask

    initial begin
        logic [23:0] mb;
        logic        m;
        int          kv0;
        int          fe0;
        logic        idle_bad;

        reset     = 1'b1;
        status_in = 8'h00;
        spi.sclk  = 1'b0;
        spi.cs_n  = 1'b1;
        spi.mosi  = 1'b0;
        wait_clk(5);
        check("rst_keycode", keycode, 8'h00);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_miso_oe", spi.miso_oe, 1'b0);
        check("rst_miso", spi.miso, 1'b0);
        reset = 1'b0;
        wait_clk(4);

        // 1: key frame 01,1A with status 63
        status_in = 8'h63;
        kv0 = kv_cnt; fe0 = fe_cnt;
        run_frame(16, {8'h01, 8'h1A, 8'h00}, 8'h63, mb);
        check("t1_keycode_latency", keycode, 8'h1A);
        wait_clk(4);
        check("t1_miso_id", mb[23:16], 8'hA5);
        check("t1_miso_status", mb[15:8], 8'h63);
        check("t1_kv_pulses", kv_cnt - kv0, 1);
        check("t1_fe_pulses", fe_cnt - fe0, 0);

        // 2: clear frame; status changes after bit 10, snapshot must hold
        status_in = 8'h3C;
        kv0 = kv_cnt; fe0 = fe_cnt;
        run_frame(16, {8'h02, 8'hFF, 8'h00}, 8'hC3, mb);
        wait_clk(4);
        check("t2_keycode", keycode, 8'h00);
        check("t2_miso_status", mb[15:8], 8'h3C);
        check("t2_kv_pulses", kv_cnt - kv0, 1);
        check("t2_fe_pulses", fe_cnt - fe0, 0);

        // Restore keycode 1A for the error-frame tests
        status_in = 8'h11;
        run_frame(16, {8'h01, 8'h1A, 8'h00}, 8'h11, mb);
        wait_clk(4);
        check("setup_keycode", keycode, 8'h1A);

        // 3: short frame (8 + 5 bits)
        kv0 = kv_cnt; fe0 = fe_cnt;
        run_frame(13, {8'h01, 5'b10110, 11'h0}, 8'h11, mb);
        wait_clk(4);
        check("t3_keycode", keycode, 8'h1A);
        check("t3_fe_pulses", fe_cnt - fe0, 1);
        check("t3_kv_pulses", kv_cnt - kv0, 0);

        // 4: long frame (16 + 3 bits), then the same frame at 16 bits
        status_in = 8'hFF;
        kv0 = kv_cnt; fe0 = fe_cnt;
        run_frame(19, {8'h01, 8'h2C, 3'b101, 5'h0}, 8'hFF, mb);
        wait_clk(4);
        check("t4_keycode", keycode, 8'h1A);
        check("t4_fe_pulses", fe_cnt - fe0, 1);
        check("t4_kv_pulses", kv_cnt - kv0, 0);
        check("t4_miso_status", mb[15:8], 8'hFF);
        check("t4_miso_tail_zero", mb[7:5], 3'b000);
        run_frame(16, {8'h01, 8'h2C, 8'h00}, 8'hFF, mb);
        wait_clk(4);
        check("t4_keycode_good", keycode, 8'h2C);

        // 5: reset after 11 bits with CS_N still low
        kv0 = kv_cnt; fe0 = fe_cnt;
        mb = {8'h01, 8'h07, 8'h00};
        cs_low();
        for (int i = 0; i < 11; i++) xfer_bit(mb[23-i], m);
        reset = 1'b1;
        wait_clk(2);
        check("t5_rst_keycode", keycode, 8'h00);
        check("t5_rst_miso", spi.miso, 1'b0);
        check("t5_rst_miso_oe", spi.miso_oe, 1'b1);
        reset = 1'b0;
        for (int i = 11; i < 16; i++) xfer_bit(mb[23-i], m);
        cs_high();
        wait_clk(4);
        check("t5_no_kv", kv_cnt - kv0, 0);
        check("t5_no_fe", fe_cnt - fe0, 0);
        check("t5_keycode_after", keycode, 8'h00);
        run_frame(16, {8'h01, 8'h07, 8'h00}, 8'hFF, mb);
        wait_clk(4);
        check("t5_keycode_new", keycode, 8'h07);

        // 6: unknown command, then SCLK activity with CS_N high
        kv0 = kv_cnt; fe0 = fe_cnt;
        run_frame(16, {8'h55, 8'h04, 8'h00}, 8'hFF, mb);
        wait_clk(4);
        check("t6_fe_pulses", fe_cnt - fe0, 1);
        check("t6_kv_pulses", kv_cnt - kv0, 0);
        check("t6_keycode", keycode, 8'h07);
        kv0 = kv_cnt; fe0 = fe_cnt;
        idle_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spi.mosi = i[0];
            wait_clk(4);
            if (spi.miso_oe !== 1'b0 || spi.miso !== 1'b0) idle_bad = 1'b1;
            spi.sclk = 1'b1;
            wait_clk(4);
            if (spi.miso_oe !== 1'b0 || spi.miso !== 1'b0) idle_bad = 1'b1;
            spi.sclk = 1'b0;
        end
        wait_clk(4);
        check("t6_idle_miso", idle_bad, 1'b0);
        check("t6_idle_pulses", (kv_cnt - kv0) + (fe_cnt - fe0), 0);
        check("t6_idle_keycode", keycode, 8'h07);
        status_in = 8'h42;
        run_frame(16, {8'h01, 8'h1A, 8'h00}, 8'h42, mb);
        wait_clk(4);
        check("t6_post_idle_id", mb[23:16], 8'hA5);
        check("t6_post_idle_keycode", keycode, 8'h1A);

        check("pulse_overlap", both_cnt, 0);
        check("pulse_stretched", long_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
